// File: rtl/motor_step_sched_if.sv
// Requester-side handshake bundle for the shared stepper scheduler: two move requests in,
// grant and completion pulses back.
interface motor_step_sched_if #(
    parameter int unsigned CNT_W = 16
);
    logic             req0;
    logic [CNT_W-1:0] steps0;
    logic             dir0;
    logic             req1;
    logic [CNT_W-1:0] steps1;
    logic             dir1;
    logic             gnt0;
    logic             gnt1;
    logic             done0;
    logic             done1;

    modport master (
        output req0, steps0, dir0, req1, steps1, dir1,
        input  gnt0, gnt1, done0, done1
    );

    modport slave (
        input  req0, steps0, dir0, req1, steps1, dir1,
        output gnt0, gnt1, done0, done1
    );
endinterface

// File: rtl/motor_step_sched.sv
// Shares one 4-coil full-step driver between two requesters: round-robin grant, step-rate
// prescaling, phase sequencing, post-move settle hold and a completion pulse to the owner.
module motor_step_sched #(
    parameter int unsigned STEP_DIV = 50000,
    parameter int unsigned SETTLE   = 1000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    motor_step_sched_if.slave  bus,
    output logic               busy,
    output logic               ina,
    output logic               ina2,
    output logic               inb,
    output logic               inb2
);
    localparam int unsigned PreW  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int unsigned HoldW = $clog2(SETTLE + 1);
    localparam logic [PreW-1:0]  PreLast  = PreW'(STEP_DIV - 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(SETTLE - 1);

    typedef enum logic [1:0] {StIdle, StMove, StHold, StFin} state_e;

    state_e           state_q, state_d;
    logic [1:0]       phase_q, phase_d;
    logic             last_q, last_d;
    logic             owner_q, owner_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] remain_q, remain_d;
    logic [PreW-1:0]  pre_q, pre_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic             done0_q, done0_d, done1_q, done1_d;
    logic             busy_q, busy_d;
    logic [3:0]       coils_q, coils_d;
    logic             pick1;
    logic             done_any;
    logic             energise;

    // Coil pattern {ina, inb, ina2, inb2} for each full-step phase.
    function automatic logic [3:0] phase_coils(logic [1:0] p);
        unique case (p)
            2'd0:    return 4'b1100;
            2'd1:    return 4'b0110;
            2'd2:    return 4'b0011;
            default: return 4'b1001;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        last_d   = last_q;
        owner_d  = owner_q;
        dir_d    = dir_q;
        remain_d = remain_q;
        pre_d    = pre_q;
        hold_d   = hold_q;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        pick1    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.req0 || bus.req1) begin
                    // last_q == 1 means requester 1 was served last, so 0 wins a tie.
                    pick1    = bus.req1 && (!bus.req0 || !last_q);
                    owner_d  = pick1;
                    last_d   = pick1;
                    gnt0_d   = !pick1;
                    gnt1_d   = pick1;
                    remain_d = pick1 ? bus.steps1 : bus.steps0;
                    dir_d    = pick1 ? bus.dir1 : bus.dir0;
                    pre_d    = '0;
                    hold_d   = '0;
                    state_d  = (remain_d == '0) ? StFin : StMove;
                end
            end
            StMove: begin
                if (pre_q == PreLast) begin
                    pre_d    = '0;
                    phase_d  = dir_q ? phase_q + 2'd1 : phase_q - 2'd1;
                    remain_d = remain_q - CNT_W'(1);
                    if (remain_q == CNT_W'(1)) begin
                        state_d = StHold;
                    end
                end else begin
                    pre_d = pre_q + PreW'(1);
                end
            end
            StHold: begin
                if (hold_q == HoldLast) begin
                    hold_d  = '0;
                    state_d = StFin;
                end else begin
                    hold_d = hold_q + HoldW'(1);
                end
            end
            StFin: begin
                // A zero-step move enters FIN straight from the grant; linger one cycle so
                // the grant and completion pulses never coincide.
                state_d = (gnt0_q || gnt1_q) ? StFin : StIdle;
            end
            default: state_d = StIdle;
        endcase

        done_any = (state_d == StFin) && (state_q != StIdle);
        energise = (state_d == StMove) || (state_d == StHold) ||
                   ((state_d == StFin) && (state_q == StHold));
        done0_d  = done_any && !owner_d;
        done1_d  = done_any && owner_d;
        busy_d   = (state_d != StIdle);
        coils_d  = energise ? phase_coils(phase_d) : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            phase_q  <= 2'd0;
            last_q   <= 1'b1;
            owner_q  <= 1'b0;
            dir_q    <= 1'b0;
            remain_q <= '0;
            pre_q    <= '0;
            hold_q   <= '0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            busy_q   <= 1'b0;
            coils_q  <= 4'b0000;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            dir_q    <= dir_d;
            remain_q <= remain_d;
            pre_q    <= pre_d;
            hold_q   <= hold_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            busy_q   <= busy_d;
            coils_q  <= coils_d;
        end
    end

    assign bus.gnt0  = gnt0_q;
    assign bus.gnt1  = gnt1_q;
    assign bus.done0 = done0_q;
    assign bus.done1 = done1_q;
    assign busy      = busy_q;
    assign {ina, inb, ina2, inb2} = coils_q;
endmodule

// File: tb/tb_motor_step_sched.sv
// Bench for motor_step_sched: a timeline model schedules expected outputs per cycle from each
// grant decision, and directed scenarios add hand-computed literal checks.
module tb_motor_step_sched;
    localparam int unsigned SD     = 4;
    localparam int unsigned ST     = 3;
    localparam int unsigned CW     = 8;
    localparam int          MaxCyc = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, ina, ina2, inb, inb2;

    motor_step_sched_if #(.CNT_W(CW)) bus ();

    motor_step_sched #(
        .STEP_DIV(SD),
        .SETTLE  (ST),
        .CNT_W   (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .busy(busy),
        .ina (ina),
        .ina2(ina2),
        .inb (inb),
        .inb2(inb2)
    );

    typedef struct packed {
        logic       gnt0;
        logic       gnt1;
        logic       done0;
        logic       done1;
        logic       busy;
        logic [3:0] coils;
    } out_t;

    out_t exp_a [MaxCyc];
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;
    bit   check_en = 1'b0;
    int   m_free   = 0;
    int   m_phase  = 0;
    bit   m_last   = 1'b1;

    always #5 clk = ~clk;

    function automatic logic [3:0] tbl(int p);
        case (p & 3)
            0:       return 4'b1100;
            1:       return 4'b0110;
            2:       return 4'b0011;
            default: return 4'b1001;
        endcase
    endfunction

    function automatic logic [3:0] coils();
        return {ina, inb, ina2, inb2};
    endfunction

    function automatic out_t act_out();
        return {bus.gnt0, bus.gnt1, bus.done0, bus.done1, busy, ina, inb, ina2, inb2};
    endfunction

    task automatic chk(string name, logic [8:0] got, logic [8:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%b want=%b (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // On a grant, lay out the whole move on the cycle timeline from the timing rules.
    task automatic model_step(int t);
        bit who, d;
        int n, g, dc, k;
        if (rst) begin
            check_en = 1'b1;
            for (int c = t + 1; c < MaxCyc; c++) exp_a[c] = '0;
            m_phase = 0;
            m_last  = 1'b1;
            m_free  = t + 1;
        end else if (t >= m_free && (bus.req0 || bus.req1)) begin
            who    = (bus.req0 && bus.req1) ? !m_last : bus.req1;
            m_last = who;
            n      = who ? int'(bus.steps1) : int'(bus.steps0);
            d      = who ? bus.dir1 : bus.dir0;
            g      = t;
            dc     = (n == 0) ? g + 2 : g + 1 + n * SD + ST;
            if (dc >= MaxCyc) dc = MaxCyc - 1;
            if (who) exp_a[g+1].gnt1 = 1'b1;
            else     exp_a[g+1].gnt0 = 1'b1;
            for (int c = g + 1; c <= dc; c++) begin
                exp_a[c].busy = 1'b1;
                if (n > 0) begin
                    k = (c - g - 1) / SD;
                    if (k > n) k = n;
                    exp_a[c].coils = tbl(m_phase + (d ? k : -k));
                end
            end
            if (who) exp_a[dc].done1 = 1'b1;
            else     exp_a[dc].done0 = 1'b1;
            m_phase = (m_phase + (d ? n : -n)) & 3;
            m_free  = dc + 1;
        end
    endtask

    initial begin
        for (int i = 0; i < MaxCyc; i++) exp_a[i] = '0;
        forever begin
            @(posedge clk);
            model_step(cyc);
            cyc++;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (check_en && cyc < MaxCyc) begin
                checks++;
                if (act_out() !== exp_a[cyc]) begin
                    failures++;
                    $display("FAIL cycle_%0d outputs got=%b want=%b", cyc, act_out(),
                             exp_a[cyc]);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_until(int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        int r, r2, r3, r4, r5;
        bus.req0 = 1'b0; bus.steps0 = '0; bus.dir0 = 1'b0;
        bus.req1 = 1'b0; bus.steps1 = '0; bus.dir1 = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk("reset_all_outputs", act_out(), 9'b0);

        // Forward move of 3 steps from phase 0.
        tick();
        r = cyc;
        bus.req0 = 1'b1; bus.steps0 = 8'd3; bus.dir0 = 1'b1;
        tick();
        bus.req0 = 1'b0;
        chk("t1_gnt0", bus.gnt0, 1);
        chk("t1_coils_first", coils(), 4'b1100);
        wait_until(r + 4);  chk("t1_coils_before_step", coils(), 4'b1100);
        wait_until(r + 5);  chk("t1_coils_step1", coils(), 4'b0110);
        chk("t1_model_step1", exp_a[r+5].coils, 4'b0110);
        wait_until(r + 9);  chk("t1_coils_step2", coils(), 4'b0011);
        wait_until(r + 13); chk("t1_coils_step3", coils(), 4'b1001);
        wait_until(r + 15); chk("t1_no_early_done", bus.done0, 0);
        wait_until(r + 16); chk("t1_done0", bus.done0, 1);
        chk("t1_model_done0", exp_a[r+16].done0, 1);
        chk("t1_coils_in_fin", coils(), 4'b1001);
        wait_until(r + 17); chk("t1_coils_off", coils(), 4'b0000);
        chk("t1_busy_off", busy, 0);

        // Reverse move of 2 steps from phase 3.
        r2 = cyc;
        bus.req1 = 1'b1; bus.steps1 = 8'd2; bus.dir1 = 1'b0;
        tick();
        bus.req1 = 1'b0;
        chk("t2_gnt1", bus.gnt1, 1);
        chk("t2_coils_first", coils(), 4'b1001);
        wait_until(r2 + 5);  chk("t2_coils_step1", coils(), 4'b0011);
        wait_until(r2 + 9);  chk("t2_coils_step2", coils(), 4'b0110);
        wait_until(r2 + 12); chk("t2_done1", bus.done1, 1);

        // Zero-step request.
        wait_until(r2 + 13);
        r3 = cyc;
        bus.req0 = 1'b1; bus.steps0 = 8'd0; bus.dir0 = 1'b1;
        tick();
        bus.req0 = 1'b0;
        chk("t4_gnt0", bus.gnt0, 1);
        chk("t4_busy1", busy, 1);
        chk("t4_coils_a", coils(), 4'b0000);
        wait_until(r3 + 2);
        chk("t4_done0", bus.done0, 1);
        chk("t4_busy2", busy, 1);
        chk("t4_coils_b", coils(), 4'b0000);
        wait_until(r3 + 3); chk("t4_busy_off", busy, 0);

        // Requester 1 waits through requester 0's move; phase 1 was kept by the zero move.
        r4 = cyc;
        bus.req0 = 1'b1; bus.steps0 = 8'd2; bus.dir0 = 1'b1;
        tick();
        bus.req0 = 1'b0;
        chk("t6_phase_kept", coils(), 4'b0110);
        bus.req1 = 1'b1; bus.steps1 = 8'd5; bus.dir1 = 1'b0;
        wait_until(r4 + 4);
        bus.steps1 = 8'd1; bus.dir1 = 1'b1;
        wait_until(r4 + 12); chk("t6_done0", bus.done0, 1);
        wait_until(r4 + 13); chk("t6_no_gnt1_yet", bus.gnt1, 0);
        wait_until(r4 + 14); chk("t6_gnt1", bus.gnt1, 1);
        chk("t6_coils_first", coils(), 4'b1001);
        bus.req1 = 1'b0; bus.steps1 = 8'd7; bus.dir1 = 1'b0;
        wait_until(r4 + 18); chk("t6_coils_step1", coils(), 4'b1100);
        wait_until(r4 + 21); chk("t6_done1", bus.done1, 1);

        // Reset mid-move, then both requesters held high.
        wait_until(r4 + 22);
        r5 = cyc;
        bus.req0 = 1'b1; bus.steps0 = 8'd3; bus.dir0 = 1'b0;
        tick();
        bus.req0 = 1'b0;
        wait_until(r5 + 6);
        rst = 1'b1;
        tick();
        chk("t5_after_reset", act_out(), 9'b0);
        rst = 1'b0;
        bus.req0 = 1'b1; bus.steps0 = 8'd1; bus.dir0 = 1'b1;
        bus.req1 = 1'b1; bus.steps1 = 8'd1; bus.dir1 = 1'b1;
        wait_until(r5 + 8);
        chk("t5_gnt0_wins", bus.gnt0, 1);
        chk("t5_phase0", coils(), 4'b1100);
        wait_until(r5 + 17);
        chk("t3_gnt1_second", bus.gnt1, 1);
        chk("t3_coils_second", coils(), 4'b0110);
        wait_until(r5 + 26); chk("t3_gnt0_third", bus.gnt0, 1);
        wait_until(r5 + 40);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        wait_until(r5 + 60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
